// File: rtl/md_unit.sv
// HI/LO multiply/divide unit for the EX stage: one operation at a time, the result
// commits to HI/LO after a fixed per-class latency, and an exception flush cancels it.
module md_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Handshake: start/op/a/b are sampled only at an edge where busy=0 and flush=0.
    // An accepted arithmetic op raises busy for its latency; done pulses for the
    // one cycle in which hi/lo first show the new result.

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam int W2      = 2 * WIDTH;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [W2-1:0]    snap_q, snap_d;
    logic             done_q, done_d;

    // Datapath operates purely on the latched operands and HI/LO snapshot.
    logic [W2-1:0]    a_sx, b_sx, a_zx, b_zx, sprod, uprod, result;
    logic [WIDTH-1:0] abs_a, abs_b, u_den, s_den;
    logic [WIDTH-1:0] uq, ur, sq, sr, sq_fix, sr_fix;
    logic             b_nz, in_arith, in_div;

    assign a_sx  = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign b_sx  = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign a_zx  = {{WIDTH{1'b0}}, a_q};
    assign b_zx  = {{WIDTH{1'b0}}, b_q};
    assign sprod = a_sx * b_sx;
    assign uprod = a_zx * b_zx;

    // Divisors are forced to 1 when zero so the dividers never see a zero.
    assign b_nz   = (b_q != '0);
    assign abs_a  = a_q[WIDTH-1] ? -a_q : a_q;
    assign abs_b  = b_q[WIDTH-1] ? -b_q : b_q;
    assign u_den  = b_nz ? b_q : WIDTH'(1);
    assign s_den  = b_nz ? abs_b : WIDTH'(1);
    assign uq     = a_q / u_den;
    assign ur     = a_q % u_den;
    assign sq     = abs_a / s_den;
    assign sr     = abs_a % s_den;
    // Most-negative / -1 falls out as quotient = a, remainder = 0 from the magnitudes.
    assign sq_fix = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -sq : sq;
    assign sr_fix = a_q[WIDTH-1] ? -sr : sr;

    always_comb begin
        result = snap_q;
        case (op_q)
            OP_MULT:  result = sprod;
            OP_MULTU: result = uprod;
            OP_DIV:   result = b_nz ? {sr_fix, sq_fix} : {a_q, {WIDTH{1'b1}}};
            OP_DIVU:  result = b_nz ? {ur, uq} : {a_q, {WIDTH{1'b1}}};
            OP_MADD:  result = snap_q + sprod;
            OP_MADDU: result = snap_q + uprod;
            OP_MSUB:  result = snap_q - sprod;
            OP_MSUBU: result = snap_q - uprod;
            default:  result = snap_q;
        endcase
    end

    assign in_arith = (op >= OP_MULT) && (op <= OP_MSUBU);
    assign in_div   = (op == OP_DIV) || (op == OP_DIVU);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        snap_d  = snap_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    if (in_arith) begin
                        state_d = S_RUN;
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                        snap_d  = {hi_q, lo_q};
                        cnt_d   = in_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d       = S_IDLE;
                    cnt_d         = '0;
                    {hi_d, lo_d}  = result;
                    done_d        = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            snap_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            snap_q  <= snap_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed cases plus random ops, results predicted by a 64-bit
// arithmetic model and matched against each done pulse by a monitor.
module tb_md_unit;

    localparam int W  = 32;
    localparam int ML = 5;
    localparam int DL = 10;

    logic          clk = 1'b0;
    logic          reset, start, flush;
    logic [3:0]    op;
    logic [W-1:0]  a, b;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    always #5 clk = ~clk;

    md_unit #(.WIDTH(W), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    int            n_cmp = 0;
    int            n_err = 0;
    logic [63:0]   exp_q[$];
    logic [31:0]   m_hi = '0, m_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                          input logic [63:0] acc);
        int          sx, sy;
        longint      sp;
        logic [63:0] up;
        sx = x;
        sy = y;
        sp = longint'(sx) * longint'(sy);
        up = {32'h0, x} * {32'h0, y};
        case (o)
            4'd1: return sp;
            4'd2: return up;
            4'd3: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, x};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            4'd4: return (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            4'd5: return acc + sp;
            4'd6: return acc + up;
            4'd7: return acc - sp;
            4'd8: return acc - up;
            default: return acc;
        endcase
    endfunction

    function automatic bit is_arith(input logic [3:0] o);
        return (o >= 4'd1) && (o <= 4'd8);
    endfunction

    function automatic int lat_of(input logic [3:0] o);
        return (o == 4'd3 || o == 4'd4) ? DL : ML;
    endfunction

    // Monitor: every done pulse consumes one expected HI/LO value.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 with {hi,lo}=%h, expected no done (t=%0t)",
                         {hi, lo}, $time);
            end else begin
                check("commit", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 4'd0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Counts busy cycles after acceptance; ends on the first negedge with busy low.
    task automatic wait_busy(output int cyc);
        cyc = 0;
        @(negedge clk);
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int          cyc;
        logic [63:0] e;
        if (is_arith(o)) begin
            e = model(o, x, y, {m_hi, m_lo});
            exp_q.push_back(e);
            issue(o, x, y);
            wait_busy(cyc);
            check("busy_len", 64'(cyc), 64'(lat_of(o)));
            {m_hi, m_lo} = e;
        end else begin
            issue(o, x, y);
            @(negedge clk);
            if (o == 4'd9)  m_hi = x;
            if (o == 4'd10) m_lo = x;
            check("busy_idle_op", 64'(busy), 64'(0));
            check("hilo_idle_op", {hi, lo}, {m_hi, m_lo});
        end
    endtask

    // Starts a multiply, then asserts flush during busy cycle fc.
    task automatic flush_at(input int fc);
        issue(4'd1, 32'd5, 32'd5);
        for (int i = 1; i <= fc; i++) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_hilo", {hi, lo}, {m_hi, m_lo});
        repeat (ML + 2) @(negedge clk);
        check("flush_hilo_late", {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        int          cyc;
        logic [63:0] e;
        logic [3:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_hilo", {hi, lo}, 64'h0);

        do_op(4'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        do_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op(4'd4, 32'h0000_1234, 32'd0);
        check("divu_zero_const", {hi, lo}, 64'h0000_1234_FFFF_FFFF);

        do_op(4'd9, 32'h0, 32'h0);
        do_op(4'd10, 32'hFFFF_FFFF, 32'h0);
        do_op(4'd6, 32'd1, 32'd1);
        check("maddu_const", {hi, lo}, 64'h0000_0001_0000_0000);
        do_op(4'd7, 32'd1, 32'd2);
        check("msub_const", {hi, lo}, 64'h0000_0000_FFFF_FFFE);

        // Flush mid-run and in the committing cycle: nothing commits.
        flush_at(3);
        flush_at(ML);

        // Flush together with start drops both MTHI and an arithmetic op.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 4'd9; a = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        op = 4'd1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; op = 4'd0;
        @(negedge clk);
        check("flush_start_busy", 64'(busy), 64'(0));
        check("flush_start_hilo", {hi, lo}, {m_hi, m_lo});

        // Starts (DIV, then MTHI) during a busy multiply are ignored.
        e = model(4'd1, 32'd7, 32'hFFFF_FFFD, {m_hi, m_lo});
        exp_q.push_back(e);
        issue(4'd1, 32'd7, 32'hFFFF_FFFD);
        cyc = 0;
        @(negedge clk);
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            start = (cyc == 2 || cyc == 3);
            op    = (cyc == 2) ? 4'd3 : 4'd9;
            a     = 32'h1111_1111;
            b     = 32'd3;
            @(negedge clk);
        end
        start = 1'b0;
        op    = 4'd0;
        check("busy_start_len", 64'(cyc), 64'(ML));
        check("busy_start_hilo", {hi, lo}, e);
        {m_hi, m_lo} = e;

        // Reset in busy cycle 2 discards the operation and clears HI/LO.
        issue(4'd1, 32'd9, 32'd9);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_hilo", {hi, lo}, 64'h0);
        m_hi = '0;
        m_lo = '0;
        repeat (ML + 2) @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            do_op(ro, ra, rb);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (DL + 4) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
